// File: rtl/mul_seq_pkg.sv
// Shared definitions for the multiply sequencer: op codes, FSM states and
// the partial-product pass table used for the high-word (MULX) operations.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'd0,
        MUL_OP_MULXUU = 2'd1,
        MUL_OP_MULXSU = 2'd2,
        MUL_OP_MULXSS = 2'd3
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_CORRECT = 3'd3,
        ST_RESP    = 3'd4
    } mul_state_e;

    localparam int MUL_PASSES = 4;

    // Left shift applied to each 16x16 partial product before accumulation.
    // Pass index bit 0 selects the high half of A, bit 1 the high half of B.
    localparam logic [5:0] PASS_SHIFT [MUL_PASSES] = '{6'd0, 6'd16, 6'd16, 6'd32};

    // Zero-extended 16-bit half of an operand, as fed to the multiply cell.
    function automatic logic [31:0] pass_operand(input logic [31:0] value,
                                                 input logic        high_half);
        return high_half ? {16'h0000, value[31:16]} : {16'h0000, value[15:0]};
    endfunction

    // Partial product placed at its weight inside the 64-bit accumulator.
    function automatic logic [63:0] shifted_partial(input logic [31:0] product,
                                                    input logic [1:0]  idx);
        return {32'h0000_0000, product} << PASS_SHIFT[idx];
    endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// Multiply sequencer sitting in front of a registered 32-bit multiply cell
// (low 32 bits of src1*src2). MUL is a single pass; MULX variants run four
// 16x16 passes, accumulate to 64 bits and apply the signed correction to
// the upper word.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | ready for a request; operands, op and tag latched on accept
// ST_ISSUE   | drive the cell: one cycle for MUL, four passes for MULX
// ST_DRAIN   | wait for the last in-flight cell result to be captured
// ST_CORRECT | MULX only: subtract signed-operand terms from the upper word
// ST_RESP    | present rsp_data/rsp_tag until rsp_ready
module mul_seq_ctrl #(
    parameter int CELL_LATENCY = 1,
    parameter int TAG_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_src1,
    input  logic [31:0]      req_src2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      cell_src1,
    output logic [31:0]      cell_src2,
    input  logic [31:0]      cell_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag
);
    import mul_seq_pkg::*;

    mul_state_e        state_q;
    mul_state_e        state_d;
    mul_op_e           op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [TAG_W-1:0]  tag_q;
    logic [63:0]       acc_q;
    logic [31:0]       result_q;
    logic [1:0]        pass_q;

    // In-flight pipe: stage i holds a pass issued i+1 cycles ago.
    logic [CELL_LATENCY-1:0] pipe_valid_q;
    logic [1:0]              pipe_idx_q [CELL_LATENCY];

    logic        accept;
    logic        issue;
    logic [1:0]  issue_idx;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        early_busy;
    logic        capture;
    logic [1:0]  capture_idx;
    logic [31:0] sub_b;
    logic [31:0] sub_a;
    logic [31:0] corrected;

    assign req_ready   = (state_q == ST_IDLE) && !reset;
    assign accept      = req_valid && req_ready;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_data    = result_q;
    assign rsp_tag     = tag_q;
    assign cell_src1   = src1;
    assign cell_src2   = src2;
    assign capture     = pipe_valid_q[CELL_LATENCY-1];
    assign capture_idx = pipe_idx_q[CELL_LATENCY-1];

    // Anything still in flight that will not be captured at this edge.
    // The last stage is excluded so DRAIN can leave on the capture edge.
    always_comb begin
        early_busy = 1'b0;
        for (int i = 0; i < CELL_LATENCY - 1; i++) begin
            early_busy = early_busy | pipe_valid_q[i];
        end
    end

    // Signed correction of the unsigned 64-bit product's upper word.
    always_comb begin
        sub_b     = '0;
        sub_a     = '0;
        if ((op_q == MUL_OP_MULXSU || op_q == MUL_OP_MULXSS) && a_q[31]) begin
            sub_b = b_q;
        end
        if (op_q == MUL_OP_MULXSS && b_q[31]) begin
            sub_a = a_q;
        end
        corrected = acc_q[63:32] - sub_b - sub_a;
    end

    // Next-state logic and cell operand drive.
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        issue_idx = pass_q;
        src1      = '0;
        src2      = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue = 1'b1;
                if (op_q == MUL_OP_MUL) begin
                    src1      = a_q;
                    src2      = b_q;
                    issue_idx = 2'd0;
                    state_d   = ST_DRAIN;
                end else begin
                    src1 = pass_operand(a_q, pass_q[0]);
                    src2 = pass_operand(b_q, pass_q[1]);
                    if (pass_q == 2'(MUL_PASSES - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!early_busy) begin
                    state_d = (op_q == MUL_OP_MUL) ? ST_RESP : ST_CORRECT;
                end
            end
            ST_CORRECT: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In-flight pipe tracking which pass each cell result belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_q <= '0;
            for (int i = 0; i < CELL_LATENCY; i++) begin
                pipe_idx_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= issue;
            pipe_idx_q[0]   <= issue_idx;
            for (int i = 1; i < CELL_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_idx_q[i]   <= pipe_idx_q[i-1];
            end
        end
    end

    // Request latch, pass counter, accumulator and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= MUL_OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            pass_q   <= '0;
        end else begin
            if (accept) begin
                op_q   <= mul_op_e'(req_op);
                a_q    <= req_src1;
                b_q    <= req_src2;
                tag_q  <= req_tag;
                acc_q  <= '0;
                pass_q <= '0;
            end else if (issue) begin
                pass_q <= pass_q + 2'd1;
            end

            if (capture) begin
                if (op_q == MUL_OP_MUL) begin
                    result_q <= cell_result;
                end else begin
                    acc_q <= acc_q + shifted_partial(cell_result, capture_idx);
                end
            end

            if (state_q == ST_CORRECT) begin
                result_q <= corrected;
            end
        end
    end

endmodule
